// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus bundle: imem request/ack, MEM redirect and the ID-side handshake.
// master = fetch queue, slave = its environment (imem + pipeline).
interface if_fetch_queue_if #(
   parameter int DEPTH = 4
) ();
   logic                     imem_req_o;
   logic [63:0]              imem_addr_o;
   logic                     imem_ack_i;
   logic [31:0]              imem_data_i;
   logic                     redirect_i;
   logic [63:0]              redirect_pc_i;
   logic                     id_ready_i;
   logic                     id_valid_o;
   logic [31:0]              id_instr_o;
   logic [63:0]              id_pc_o;
   logic [$clog2(DEPTH):0]   count_o;

   modport master (
      output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, count_o,
      input  imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, id_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o, count_o,
      output imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, id_ready_i
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch front-end: one-outstanding imem fetch FSM feeding a PC/instr FIFO towards ID.
// Optional IFQ_BYPASS_EN: combinational imem->ID path when the queue is empty and ID is ready.
module if_fetch_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic             clk_i,
   input  logic             rst_i,
   if_fetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

   state_e          state_q, state_d;
   logic            req_q, req_d;
   logic [63:0]     addr_q, addr_d;
   logic [63:0]     fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [63:0]     pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];

   logic            ack, pop, push, byp;
   logic [63:0]     redir_pc;
   logic [CW-1:0]   count_after;

   // An ack outside an active request is ignored rather than trusted.
   assign ack      = bus.imem_ack_i & req_q;
   assign pop      = (count_q != '0) & bus.id_ready_i;
   assign redir_pc = bus.redirect_pc_i & ~64'h3;

`ifdef IFQ_BYPASS_EN
   assign byp = ack & (state_q == REQ) & (count_q == '0) & bus.id_ready_i & ~bus.redirect_i;
`else
   assign byp = 1'b0;
`endif

   assign push        = ack & (state_q == REQ) & ~bus.redirect_i & ~byp;
   assign count_after = count_q + CW'(push) - CW'(pop);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count_after;
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      wr_ptr_d   = wr_ptr_q + AW'(push);

      unique case (state_q)
         IDLE: begin
            // Space freed by this cycle's pop is enough to reserve the next slot.
            if (count_q < DEPTH_C || pop) begin
               state_d = REQ;
               addr_d  = fetch_pc_q;
            end
         end
         REQ: begin
            if (ack) begin
               fetch_pc_d = fetch_pc_q + 64'd4;
               if (count_after < DEPTH_C) begin
                  addr_d = fetch_pc_q + 64'd4;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            if (ack) begin
               state_d = REQ;
               addr_d  = fetch_pc_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.redirect_i) begin
         fetch_pc_d = redir_pc;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // An unanswered request must still be closed out before the new address goes out.
         if (req_q && !ack) begin
            state_d = DROP;
            addr_d  = addr_q;
         end else begin
            state_d = REQ;
            addr_d  = redir_pc;
         end
      end
   end

   assign req_d = (state_d != IDLE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= '0;
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= bus.imem_data_i;
      end
   end

   always_comb begin
      bus.id_valid_o = (count_q != '0);
      bus.id_instr_o = NOP_INSTR;
      bus.id_pc_o    = '0;
      if (count_q != '0) begin
         bus.id_instr_o = instr_mem_q[rd_ptr_q];
         bus.id_pc_o    = pc_mem_q[rd_ptr_q];
      end
`ifdef IFQ_BYPASS_EN
      if (byp) begin
         bus.id_valid_o = 1'b1;
         bus.id_instr_o = bus.imem_data_i;
         bus.id_pc_o    = addr_q;
      end
`endif
   end

   assign bus.imem_req_o  = req_q;
   assign bus.imem_addr_o = addr_q;
   assign bus.count_o     = count_q;

   a_ack_in_req: assert property (@(posedge clk_i) disable iff (!rst_i)
      bus.imem_ack_i |-> req_q);
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
      push |-> (count_q < DEPTH_C));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: latency-configurable imem model plus an in-order PC/instr scoreboard.
module tb_if_fetch_queue;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   if_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

   if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   // imem model: ack after lat wait cycles, data derived from the address
   int lat = 0;
   int mcnt;
   assign bus.imem_ack_i  = bus.imem_req_o && (mcnt >= lat);
   assign bus.imem_data_i = ~bus.imem_addr_o[31:0];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   mcnt <= 0;
      else if (bus.imem_ack_i || !bus.imem_req_o)   mcnt <= 0;
      else                                          mcnt <= mcnt + 1;
   end

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        sb[$];
   logic [63:0] exp_fetch;
   bit          drop_pend;
   bit          t1_mode;
   int          ack_cnt;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Sampled at negedge: sees the inputs and outputs that the next posedge acts on.
   task automatic mon();
      ent_t e;
      if (!rst_n) begin
         sb.delete();
         exp_fetch = 64'h0;
         drop_pend = 1'b0;
         return;
      end
      if (!bus.id_valid_o) begin
         chk("empty_instr", 64'(bus.id_instr_o), 64'(NOP));
         chk("empty_pc", bus.id_pc_o, 64'h0);
      end
      if (t1_mode) chk("t1_count_le1", 64'(bus.count_o <= 1), 64'd1);
      if (bus.imem_ack_i) ack_cnt++;
      if (bus.redirect_i) begin
         sb.delete();
         exp_fetch = bus.redirect_pc_i & ~64'h3;
         drop_pend = bus.imem_req_o && !bus.imem_ack_i;
      end else begin
         if (bus.id_valid_o && bus.id_ready_i) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("id_pc", bus.id_pc_o, e.pc);
               chk("id_instr", 64'(bus.id_instr_o), 64'(e.instr));
            end
         end
         if (bus.imem_ack_i) begin
            if (drop_pend) begin
               drop_pend = 1'b0;
            end else begin
               chk("fetch_addr", bus.imem_addr_o, exp_fetch);
               sb.push_back('{pc: exp_fetch, instr: ~exp_fetch[31:0]});
               exp_fetch = exp_fetch + 64'd4;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit rdy, input int l);
      rst_n             = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 64'h0;
      bus.id_ready_i    = rdy;
      lat               = l;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   64'(bus.imem_req_o), 64'd0);
      chk({tag, "_addr"},  bus.imem_addr_o, 64'h0);
      chk({tag, "_valid"}, 64'(bus.id_valid_o), 64'd0);
      chk({tag, "_instr"}, 64'(bus.id_instr_o), 64'(NOP));
      chk({tag, "_pc"},    bus.id_pc_o, 64'h0);
      chk({tag, "_count"}, 64'(bus.count_o), 64'd0);
   endtask

   initial begin
      int base;
      ack_cnt = 0;
      t1_mode = 1'b0;

      // T1: zero-wait streaming with ID always ready
      do_reset(1'b1, 0);
      chk_reset_vals("rst");
      t1_mode = 1'b1;
      tick();
      chk("t1_req", 64'(bus.imem_req_o), 64'd1);
      chk("t1_addr0", bus.imem_addr_o, 64'h0);
      tick();
      chk("t1_addr4", bus.imem_addr_o, 64'h4);
      chk("t1_valid", 64'(bus.id_valid_o), 64'd1);
      chk("t1_pc0", bus.id_pc_o, 64'h0);
      tick();
      chk("t1_addr8", bus.imem_addr_o, 64'h8);
      chk("t1_pc4", bus.id_pc_o, 64'h4);
      repeat (16) tick();
      t1_mode = 1'b0;

      // T2: ID stalled fills the queue, then drains without gaps
      do_reset(1'b0, 0);
      base = ack_cnt;
      for (int i = 0; i < 50 && !bus.imem_req_o; i++) tick();
      chk("t2_req_up", 64'(bus.imem_req_o), 64'd1);
      for (int i = 0; i < 50 && bus.imem_req_o; i++) tick();
      chk("t2_req_down", 64'(bus.imem_req_o), 64'd0);
      chk("t2_count4", 64'(bus.count_o), 64'd4);
      chk("t2_pushes", 64'(ack_cnt - base), 64'd4);
      chk("t2_pc0", bus.id_pc_o, 64'h0);
      repeat (3) tick();
      chk("t2_hold_req", 64'(bus.imem_req_o), 64'd0);
      chk("t2_hold_pc", bus.id_pc_o, 64'h0);
      bus.id_ready_i = 1'b1;
      tick();
      chk("t2_resume", bus.imem_addr_o, 64'h10);
      for (int i = 0; i < 10; i++) begin
         chk("t2_nogap", 64'(bus.id_valid_o), 64'd1);
         tick();
      end

      // T3: redirect while a slow request is outstanding -> DROP
      do_reset(1'b1, 3);
      for (int i = 0; i < 100 && !(bus.imem_req_o && bus.imem_addr_o == 64'h8); i++) tick();
      chk("t3_req8", bus.imem_addr_o, 64'h8);
      tick();
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 64'h100;
      tick();
      bus.redirect_i = 1'b0;
      chk("t3_drop_req", 64'(bus.imem_req_o), 64'd1);
      chk("t3_drop_addr", bus.imem_addr_o, 64'h8);
      for (int i = 0; i < 50 && bus.imem_addr_o != 64'h100; i++) tick();
      chk("t3_newaddr", bus.imem_addr_o, 64'h100);
      for (int i = 0; i < 50 && !bus.id_valid_o; i++) tick();
      chk("t3_first_pc", bus.id_pc_o, 64'h100);
      repeat (10) tick();

      // T4: redirect coinciding with ack and pop at count 2
      do_reset(1'b0, 0);
      for (int i = 0; i < 50 && bus.count_o != 2; i++) tick();
      chk("t4_count2", 64'(bus.count_o), 64'd2);
      bus.id_ready_i    = 1'b1;
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 64'h200;
      tick();
      bus.redirect_i = 1'b0;
      chk("t4_count0", 64'(bus.count_o), 64'd0);
      chk("t4_valid0", 64'(bus.id_valid_o), 64'd0);
      chk("t4_nop", 64'(bus.id_instr_o), 64'(NOP));
      chk("t4_addr", bus.imem_addr_o, 64'h200);
      for (int i = 0; i < 50 && !bus.id_valid_o; i++) tick();
      chk("t4_first_pc", bus.id_pc_o, 64'h200);
      repeat (6) tick();

      // T5: 64-bit fetch PC wrap
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      bus.redirect_i = 1'b0;
      chk("t5_top", bus.imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      chk("t5_wrap", bus.imem_addr_o, 64'h0);
      repeat (8) tick();

      // T6: asynchronous reset in the middle of a request with count 3
      do_reset(1'b0, 2);
      for (int i = 0; i < 100 && !(bus.count_o == 3 && bus.imem_req_o); i++) tick();
      chk("t6_count3", 64'(bus.count_o), 64'd3);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("t6_async");
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20 && !bus.imem_req_o; i++) tick();
      chk("t6_req", 64'(bus.imem_req_o), 64'd1);
      chk("t6_addr", bus.imem_addr_o, 64'h0);
      repeat (8) tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
